seq_signed_divider: RTL and testbench

//   Iterative signed divider; the division half of the multdiv unit, next to the multiplier and its
//   64->32 product overflow check. Latches a dividend/divisor on a start pulse and retires one quotient
//   bit per clock (restoring, on magnitudes), then sign-corrects. Reports quotient, remainder and an

---
 rtl/seq_signed_divider.sv | 194 +++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Iterative signed divider (restoring, one quotient bit per clock on magnitudes).
// Operands are latched on ctrl_div and the quotient is truncated toward zero.
// The remainder takes the sign of the dividend. The result is sign-corrected in a
// final FIX step. Divide-by-zero and MIN / -1 skip the iteration and report an
// exception. Results are staged internally and published together with the
// one-cycle ready pulse.
module seq_signed_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's complement negation over WIDTH bits (MIN maps to itself).
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned magnitude of a signed value; |MIN| comes out as 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_quo;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_div;        // divisor magnitude
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_stage_q;
    logic [WIDTH-1:0] r_stage_r;
    logic             r_stage_e;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exception;
    logic             r_rdy;
    logic             r_busy;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_exc_start;
    logic [WIDTH:0]   w_shift_full;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;

    // Operand classification and one restoring-division step.
    always_comb begin
        w_abs_a      = f_abs(data_operandA);
        w_abs_b      = f_abs(data_operandB);
        w_b_zero     = (data_operandB == ZERO_VAL);
        w_ovf        = (data_operandA == MIN_VAL) && (data_operandB == ONES_VAL);
        w_exc_start  = w_b_zero || w_ovf;
        // W+1-bit shifted remainder so the compare never loses the carry-out bit.
        w_shift_full = {r_rem, r_quo[WIDTH-1]};
        w_ge         = (w_shift_full >= {1'b0, r_div});
        // When w_ge holds, the difference is below |B| <= 2**(W-1), so W bits suffice.
        w_diff       = w_shift_full[WIDTH-1:0] - r_div;
        if (w_ge) begin
            w_rem_next = w_diff;
        end else begin
            w_rem_next = w_shift_full[WIDTH-1:0];
        end
        w_quo_next   = {r_quo[WIDTH-2:0], w_ge};
        w_last       = (r_cnt == LAST_CNT);
    end

    // Next-state logic; a start pulse in any state (re)launches an operation.
    always_comb begin
        w_next_state = r_state;
        if (ctrl_div) begin
            if (w_exc_start) begin
                w_next_state = S_DONE;
            end else begin
                w_next_state = S_RUN;
            end
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_RUN:   w_next_state = w_last ? S_FIX : S_RUN;
                S_FIX:   w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register and busy flag (busy tracks RUN/FIX of the next cycle).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_RUN) || (w_next_state == S_FIX);
        end
    end

    // Operand latch, iteration datapath and staged result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_rem     <= ZERO_VAL;
            r_quo     <= ZERO_VAL;
            r_div     <= ZERO_VAL;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_stage_q <= ZERO_VAL;
            r_stage_r <= ZERO_VAL;
            r_stage_e <= 1'b0;
        end else if (ctrl_div) begin
            r_cnt <= {CNT_W{1'b0}};
            r_rem <= ZERO_VAL;
            r_quo <= w_abs_a;
            r_div <= w_abs_b;
            r_sa  <= data_operandA[WIDTH-1];
            r_sb  <= data_operandB[WIDTH-1];
            if (w_exc_start) begin
                // Divide-by-zero reports 0; MIN / -1 reports the wrapped quotient MIN.
                r_stage_q <= w_b_zero ? ZERO_VAL : MIN_VAL;
                r_stage_r <= ZERO_VAL;
                r_stage_e <= 1'b1;
            end else begin
                r_stage_q <= r_stage_q;
                r_stage_r <= r_stage_r;
                r_stage_e <= r_stage_e;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_ONE;
        end else if (r_state == S_FIX) begin
            r_stage_q <= (r_sa ^ r_sb) ? f_neg(r_quo) : r_quo;
            r_stage_r <= r_sa ? f_neg(r_rem) : r_rem;
            r_stage_e <= 1'b0;
        end else begin
            r_cnt <= r_cnt;
            r_rem <= r_rem;
            r_quo <= r_quo;
        end
    end

    // Publish the staged result together with the one-cycle ready pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= ZERO_VAL;
            r_remainder <= ZERO_VAL;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_result    <= r_stage_q;
            r_remainder <= r_stage_r;
            r_exception <= r_stage_e;
            r_rdy       <= 1'b1;
        end else begin
            r_rdy       <= 1'b0;
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=32): directed scenarios,
// abort/reset cases and randomized operands against the language's signed / and %.
module tb_seq_signed_divider;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    seq_signed_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Pulse ctrl_div for one edge (edge 0), then wait (bounded) for RDY.
    // lat = number of edges after edge 0 at which RDY was seen, -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic e,
                          output int lat, output logic busy_seen, output logic tail_ok);
        @(negedge clock);
        ctrl_div = 1'b1; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_div = 1'b0;
        lat = -1;
        busy_seen = busy;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = n;
                break;
            end
            busy_seen = busy_seen | busy;
        end
        q = data_result; r = data_remainder; e = data_exception;
        @(negedge clock);
        tail_ok = !data_resultRDY && !busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++; if (data_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", data_result); end
        n_vec++; if (data_remainder !== 32'd0) begin n_bad++; $display("FAIL reset_rem: got %h want 0", data_remainder); end
        n_vec++; if (data_exception !== 1'b0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", data_exception); end
        n_vec++; if (data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Directed table: basic, sign combinations, divide-by-zero, MIN cases.
    task automatic test_directed();
        logic [31:0] ta[7];
        logic [31:0] tb_[7];
        exp_t        te[7];
        logic [31:0] q, r;
        logic        e, bs, tail;
        int          lat;
        exp_t        ex;
        ta[0] = 32'd100;        tb_[0] = 32'd7;          te[0] = '{32'd14,         32'd2,          1'b0, 8'd34};
        ta[1] = -32'sd100;      tb_[1] = 32'd7;          te[1] = '{32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 8'd34};
        ta[2] = 32'd100;        tb_[2] = -32'sd7;        te[2] = '{32'hFFFF_FFF2,  32'd2,          1'b0, 8'd34};
        ta[3] = 32'd12345;      tb_[3] = 32'd0;          te[3] = '{32'd0,          32'd0,          1'b1, 8'd1};
        ta[4] = 32'h8000_0000;  tb_[4] = 32'hFFFF_FFFF;  te[4] = '{32'h8000_0000,  32'd0,          1'b1, 8'd1};
        ta[5] = 32'h8000_0000;  tb_[5] = 32'd2;          te[5] = '{32'hC000_0000,  32'd0,          1'b0, 8'd34};
        ta[6] = -32'sd100;      tb_[6] = -32'sd7;        te[6] = '{32'd14,         32'hFFFF_FFFE,  1'b0, 8'd34};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(te[i]);
            run_op(ta[i], tb_[i], q, r, e, lat, bs, tail);
            ex = sb.pop_front();
            n_vec++; if (q !== ex.q) begin n_bad++; $display("FAIL dir%0d_q: got %h want %h", i, q, ex.q); end
            n_vec++; if (r !== ex.r) begin n_bad++; $display("FAIL dir%0d_r: got %h want %h", i, r, ex.r); end
            n_vec++; if (e !== ex.e) begin n_bad++; $display("FAIL dir%0d_exc: got %b want %b", i, e, ex.e); end
            n_vec++; if (lat !== int'(ex.lat)) begin n_bad++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, ex.lat); end
            n_vec++; if (bs !== !ex.e) begin n_bad++; $display("FAIL dir%0d_busy: got %b want %b", i, bs, !ex.e); end
            n_vec++; if (tail !== 1'b1) begin n_bad++; $display("FAIL dir%0d_pulse: got %b want 1", i, tail); end
        end
    endtask

    // Re-pulse at edge 10: the first op is abandoned, only the second reports.
    task automatic test_abort();
        int   lat = -1;
        int   early = 0;
        exp_t ex;
        @(negedge clock);
        ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(negedge clock);
        ctrl_div = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clock);
            if (data_resultRDY) early++;
        end
        ctrl_div = 1'b1; data_operandA = 32'd50; data_operandB = 32'd5;
        sb.push_back('{32'd10, 32'd0, 1'b0, 8'd34});
        @(negedge clock);
        ctrl_div = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clock);
            if (data_resultRDY) begin lat = n; break; end
        end
        ex = sb.pop_front();
        n_vec++; if (early !== 0) begin n_bad++; $display("FAIL abort_early_rdy: got %0d want 0", early); end
        n_vec++; if (lat !== int'(ex.lat)) begin n_bad++; $display("FAIL abort_lat: got %0d want %0d", lat, ex.lat); end
        n_vec++; if (data_result !== ex.q) begin n_bad++; $display("FAIL abort_q: got %h want %h", data_result, ex.q); end
        n_vec++; if (data_remainder !== ex.r) begin n_bad++; $display("FAIL abort_r: got %h want %h", data_remainder, ex.r); end
        @(negedge clock);
    endtask

    // Reset at edge 15 of an operation: outputs clear and no RDY ever follows.
    task automatic test_reset_mid();
        int          rdy_cnt = 0;
        logic [31:0] q, r;
        logic        e, bs, tail;
        int          lat;
        exp_t        ex;
        @(negedge clock);
        ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(negedge clock);
        ctrl_div = 1'b0;
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++; if (data_result !== 32'd0) begin n_bad++; $display("FAIL rstmid_q: got %h want 0", data_result); end
        n_vec++; if (data_remainder !== 32'd0) begin n_bad++; $display("FAIL rstmid_r: got %h want 0", data_remainder); end
        n_vec++; if (data_exception !== 1'b0) begin n_bad++; $display("FAIL rstmid_exc: got %b want 0", data_exception); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_cnt++;
        end
        n_vec++; if (rdy_cnt !== 0) begin n_bad++; $display("FAIL rstmid_ghost: got %0d want 0", rdy_cnt); end
        sb.push_back('{32'd2, 32'd1, 1'b0, 8'd34});
        run_op(32'd9, 32'd4, q, r, e, lat, bs, tail);
        ex = sb.pop_front();
        n_vec++; if (q !== ex.q) begin n_bad++; $display("FAIL rstmid_next_q: got %h want %h", q, ex.q); end
        n_vec++; if (r !== ex.r) begin n_bad++; $display("FAIL rstmid_next_r: got %h want %h", r, ex.r); end
        n_vec++; if (lat !== int'(ex.lat)) begin n_bad++; $display("FAIL rstmid_next_lat: got %0d want %0d", lat, ex.lat); end
    endtask

    // Randomized operands against the simulator's signed division.
    task automatic test_random(input int count);
        logic signed [31:0] sa, sbv, qr, rr;
        logic [31:0]        q, r;
        logic               e, bs, tail;
        int                 lat;
        int                 done = 0;
        exp_t               ex;
        while (done < count) begin
            case ($urandom_range(0, 3))
                0:       begin sa = $signed($urandom()); sbv = $signed($urandom()); end
                1:       begin sa = $signed($urandom()); sbv = $signed(32'($urandom_range(0, 40))) - 32'sd20; end
                2:       begin sa = $signed(32'($urandom_range(0, 2000))) - 32'sd1000; sbv = $signed($urandom()); end
                default: begin sa = (($urandom_range(0, 1) == 0) ? 32'sh8000_0000 : 32'sh7FFF_FFFF);
                               sbv = $signed($urandom()) >>> $urandom_range(0, 31); end
            endcase
            if (sbv == 32'sd0 || (sa == 32'sh8000_0000 && sbv == -32'sd1)) continue;
            qr = sa / sbv;
            rr = sa % sbv;
            sb.push_back('{qr, rr, 1'b0, 8'd34});
            run_op(sa, sbv, q, r, e, lat, bs, tail);
            ex = sb.pop_front();
            n_vec++; if (q !== ex.q) begin n_bad++; $display("FAIL rnd_q: a=%h b=%h got %h want %h", sa, sbv, q, ex.q); end
            n_vec++; if (r !== ex.r) begin n_bad++; $display("FAIL rnd_r: a=%h b=%h got %h want %h", sa, sbv, r, ex.r); end
            n_vec++; if (e !== ex.e) begin n_bad++; $display("FAIL rnd_exc: a=%h b=%h got %b want 0", sa, sbv, e); end
            n_vec++; if (lat !== int'(ex.lat)) begin n_bad++; $display("FAIL rnd_lat: a=%h b=%h got %0d want 34", sa, sbv, lat); end
            done++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_random(1400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
